// File: rtl/cache_pkg.sv
// Shared cache definitions: line geometry, word-address layout and refill FSM encoding.
package cache_pkg;

  localparam int unsigned TAG_W          = 3;
  localparam int unsigned IDX_W          = 10;
  localparam int unsigned OFF_W          = 2;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned LINE_ADDR_W    = TAG_W + IDX_W + OFF_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } word_addr_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    FULL     = 2'd3
  } refill_state_e;

endpackage

// File: rtl/line_refill_ctrl_if.sv
// Miss request, memory read and line delivery signals between cache, refill controller and memory.
interface line_refill_ctrl_if
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) ();

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              mem_rd_valid;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [IDX_W-1:0]  line_index;
  logic [DATA_W-1:0] line_w3;
  logic [DATA_W-1:0] line_w2;
  logic [DATA_W-1:0] line_w1;
  logic [DATA_W-1:0] line_w0;
  logic              line_ack;
  logic [CNT_W-1:0]  refill_cnt;

  // Cache/memory side.
  modport master (
    output req_valid, req_addr, mem_rd_ready, mem_rsp_valid, mem_rsp_data, line_ack,
    input  req_ready, mem_rd_valid, mem_rd_addr, line_valid, line_tag, line_index,
    input  line_w3, line_w2, line_w1, line_w0, refill_cnt
  );

  // Refill controller side.
  modport slave (
    input  req_valid, req_addr, mem_rd_ready, mem_rsp_valid, mem_rsp_data, line_ack,
    output req_ready, mem_rd_valid, mem_rd_addr, line_valid, line_tag, line_index,
    output line_w3, line_w2, line_w1, line_w0, refill_cnt
  );

endinterface

// File: rtl/line_refill_ctrl.sv
// Cache line refill controller: fetches the four words of a missing line one read at a time,
// presents the assembled line until the cache acknowledges it, and counts completed refills.
module line_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  line_refill_ctrl_if.slave bus
);

  refill_state_e     state_q;
  refill_state_e     state_d;
  word_addr_t        base_q;
  word_addr_t        req_line_c;
  word_addr_t        rd_addr_c;
  logic [OFF_W-1:0]  k_q;
  logic [DATA_W-1:0] word_q [WORDS_PER_LINE];
  logic [CNT_W-1:0]  cnt_q;

  logic req_ready_q, req_ready_d;
  logic rd_valid_q,  rd_valid_d;
  logic line_valid_q, line_valid_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stray responses and acks fall through without effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.req_valid)    state_d = ISSUE;
      ISSUE:    if (bus.mem_rd_ready) state_d = WAIT_RSP;
      WAIT_RSP: if (bus.mem_rsp_valid)
                  state_d = (k_q == OFF_W'(WORDS_PER_LINE - 1)) ? FULL : ISSUE;
      FULL:     if (bus.line_ack)     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flopped outputs track state_q.
  always_comb begin
    req_ready_d  = 1'b0;
    rd_valid_d   = 1'b0;
    line_valid_d = 1'b0;
    case (state_d)
      IDLE:    req_ready_d  = 1'b1;
      ISSUE:   rd_valid_d   = 1'b1;
      FULL:    line_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q  <= 1'b1;
      rd_valid_q   <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      req_ready_q  <= req_ready_d;
      rd_valid_q   <= rd_valid_d;
      line_valid_q <= line_valid_d;
    end
  end

  // Line-aligned base of the incoming miss.
  always_comb begin
    req_line_c        = word_addr_t'(LINE_ADDR_W'(bus.req_addr));
    req_line_c.offset = '0;
  end

  // Base offset is always zero, so OR-ing in k selects the word without touching tag/index.
  always_comb begin
    rd_addr_c        = base_q;
    rd_addr_c.offset = base_q.offset | k_q;
  end

  // Datapath: base, word counter, line buffer and refill counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) word_q[i] <= '0;
    end else begin
      if (state_q == IDLE && bus.req_valid) begin
        base_q <= req_line_c;
        k_q    <= '0;
      end
      if (state_q == WAIT_RSP && bus.mem_rsp_valid) begin
        word_q[k_q] <= bus.mem_rsp_data;
        if (k_q != OFF_W'(WORDS_PER_LINE - 1)) k_q <= k_q + OFF_W'(1);
      end
      if (state_q == FULL && bus.line_ack && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.mem_rd_valid = rd_valid_q;
  assign bus.mem_rd_addr  = ADDR_W'(rd_addr_c);
  assign bus.line_valid   = line_valid_q;
  assign bus.line_tag     = base_q.tag;
  assign bus.line_index   = base_q.index;
  assign bus.line_w0      = word_q[0];
  assign bus.line_w1      = word_q[1];
  assign bus.line_w2      = word_q[2];
  assign bus.line_w3      = word_q[3];
  assign bus.refill_cnt   = cnt_q;

endmodule

// File: doc/line_refill_ctrl.md
LINE_REFILL_CTRL -- requirements
Module: line_refill_ctrl

Interface
REQ-001 Parameter ADDR_W, 15, word-address width {tag[14:12], index[11:2], offset[1:0]}.
REQ-002 Parameter DATA_W, 32, memory word width.
REQ-003 Parameter CNT_W, 16, refill counter width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  cache reports a miss needing a line fill.
REQ-007 req_addr  input  ADDR_W  missing word address.
REQ-008 req_ready  output  1  controller idle and able to accept a miss.
REQ-009 mem_rd_valid  output  1  read command valid to main memory.
REQ-010 mem_rd_addr  output  ADDR_W  word address being read.
REQ-011 mem_rd_ready  input  1  memory accepts the read command.
REQ-012 mem_rsp_valid  input  1  read data valid, one per accepted command, in order.
REQ-013 mem_rsp_data  input  DATA_W  read data.
REQ-014 line_valid  output  1  assembled line available to the cache.
REQ-015 line_tag / line_index  output  3 / 10  tag and index of the assembled line.
REQ-016 line_w3, line_w2, line_w1, line_w0  output  DATA_W each  line words, w0 = offset 0; drive the cache's miss_data4..miss_data1.
REQ-017 line_ack  input  1  cache has written the line.
REQ-018 refill_cnt  output  CNT_W  number of completed refills.

Function
REQ-019 States: IDLE, ISSUE, WAIT_RSP, FULL; req_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: req_valid=1 latches base = {req_addr[14:2], 2'b00}, clears word counter k to 0, goes to ISSUE.
REQ-021 ISSUE: mem_rd_valid=1, mem_rd_addr = base + k; hold both stable until mem_rd_ready=1, then go to WAIT_RSP.
REQ-022 WAIT_RSP: mem_rd_valid=0; on mem_rsp_valid=1 capture mem_rsp_data into word k; if k=3 go to FULL, else increment k and return to ISSUE.
REQ-023 mem_rsp_valid in IDLE, ISSUE or FULL is ignored (no capture, no state change).
REQ-024 FULL: line_valid=1, line_tag = base[14:12], line_index = base[11:2], words stable; on line_ack=1 go to IDLE and increment refill_cnt.
REQ-025 refill_cnt saturates at all-ones; no wrap.
REQ-026 line_ack outside FULL is ignored.
REQ-027 Latency: with mem_rd_ready=1 always and response one cycle after acceptance, line_valid first rises 9 cycles after the req accept cycle.
REQ-028 New miss presented with line_ack in FULL is not accepted that cycle; it is accepted in the following IDLE cycle.
REQ-029 Word addresses never cross the line: offset wraps only within 0..3; base tag/index bits are never modified by the increment.
REQ-030 mem_rd_valid SHALL never be 1 while a response is outstanding (one read in flight maximum).

Reset
REQ-031 rst=1 SHALL immediately force IDLE, k=0, base=0, all line words=0, refill_cnt=0, line_valid=0, mem_rd_valid=0, mem_rd_addr=0.
REQ-032 Reset mid-refill abandons the line; a late mem_rsp_valid after reset is ignored per REQ-023.
REQ-033 After rst deasserts, req_ready=1 in the first cycle.

Structure
REQ-034 TAG_W=3, IDX_W=10, OFF_W=2, WORDS_PER_LINE=4 and the state encoding SHALL live in shared package cache_pkg, also used by the cache.
REQ-035 Single flat module; no sub-module (the FSM and 4-word line buffer are too small to split).

Verification
REQ-036 Miss at addr 0x1005, memory returns 0xA0..0xA3 with zero wait -> reads at 0x1004..0x1007 in order, line_valid at cycle +9, tag=1, index=1, w0..w3=0xA0..0xA3.
REQ-037 mem_rd_ready held low 5 cycles on word 2 -> mem_rd_addr=0x1006 and mem_rd_valid stable throughout, no extra command issued.
REQ-038 Spurious mem_rsp_valid with data 0xDEAD in IDLE and in ISSUE -> no word changes, state unchanged.
REQ-039 rst pulsed after word 1 captured -> all outputs zero, req_ready=1 next cycle, new miss 0x7FFF reads 0x7FFC..0x7FFF.
REQ-040 Line held in FULL for 10 cycles with req_valid=1 -> outputs stable, req_ready=0; line_ack -> refill_cnt +1, new req accepted the next cycle.
REQ-041 refill_cnt preset path: 65536 back-to-back refills -> refill_cnt stays 0xFFFF.
